// File: rtl/jtag_bsr_chain.sv
// rtl/jtag_bsr_chain.sv - boundary-scan register chain driven by the TAP bsr_* strobes
//
// Purpose:
//   WIDTH observe-and-control cells in a serial chain between bsr_tdi and
//   bsr_tdo. Cells capture synchronised pad values and shift them out through
//   the TAP. An update register drives the pads when boundary-scan mode is
//   active, and functional values pass straight through otherwise.
//
// Ports:
//   clk         single clock, shared with the TAP
//   rst         synchronous, active-high reset
//   bsr_tdi     serial data from the TAP into cell WIDTH-1
//   bsr_clk     per-cycle enable for one capture or shift
//   bsr_shift   with bsr_clk high: 1 = shift, 0 = capture
//   bsr_update  rising edge copies the chain into the update register
//   bsr_mode    1 = pads driven from the update register, 0 = passthrough
//   bsr_tdo     serial data to the TAP, always chain cell 0
//   sys_in      functional pad values from the core
//   pin_in      asynchronous pad observation inputs
//   pin_out     pad drive values

module jtag_bsr_chain #(
  parameter int                WIDTH       = 8,
  parameter int                SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0]  UPD_RESET   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bsr_tdi,
  input  logic             bsr_clk,
  input  logic             bsr_shift,
  input  logic             bsr_update,
  input  logic             bsr_mode,
  output logic             bsr_tdo,
  input  logic [WIDTH-1:0] sys_in,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pin_out
);

  logic [WIDTH-1:0] sync [SYNC_STAGES];
  logic [WIDTH-1:0] pin_s;
  logic [WIDTH-1:0] chain;
  logic [WIDTH-1:0] upd;
  logic             upd_prev;
  logic             mode_q;
  logic             upd_edge;

  assign pin_s    = sync[SYNC_STAGES-1];
  assign upd_edge = bsr_update && !upd_prev;

  // Synchroniser pipeline for the asynchronous pad inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync[i] <= '0;
      end
    end else begin
      sync[0] <= pin_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync[i] <= sync[i-1];
      end
    end
  end

  // Capture/shift register. Cell 0 leaves first; bsr_tdi enters at the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else if (bsr_clk) begin
      if (bsr_shift) begin
        chain <= {bsr_tdi, chain[WIDTH-1:1]};
      end else begin
        chain <= pin_s;
      end
    end
  end

  // Update register loads once per rising edge of bsr_update. It samples the
  // chain as it was before any shift/capture on the same clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      upd      <= UPD_RESET;
      upd_prev <= 1'b0;
      mode_q   <= 1'b0;
    end else begin
      if (upd_edge) begin
        upd <= chain;
      end
      upd_prev <= bsr_update;
      mode_q   <= bsr_mode;
    end
  end

  assign bsr_tdo = chain[0];

  // Pad mux: registered select, combinational path from sys_in.
  always_comb begin
    pin_out = sys_in;
    if (mode_q) begin
      pin_out = upd;
    end
  end

endmodule

// File: tb/tb_jtag_bsr_chain.sv
// tb/tb_jtag_bsr_chain.sv - directed self-checking bench for jtag_bsr_chain

module tb_jtag_bsr_chain;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         bsr_tdi;
  logic         bsr_clk;
  logic         bsr_shift;
  logic         bsr_update;
  logic         bsr_mode;
  logic         bsr_tdo;
  logic [W-1:0] sys_in;
  logic [W-1:0] pin_in;
  logic [W-1:0] pin_out;

  int checks   = 0;
  int failures = 0;

  jtag_bsr_chain #(
    .WIDTH       (W),
    .SYNC_STAGES (2),
    .UPD_RESET   (8'hA5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bsr_tdi    (bsr_tdi),
    .bsr_clk    (bsr_clk),
    .bsr_shift  (bsr_shift),
    .bsr_update (bsr_update),
    .bsr_mode   (bsr_mode),
    .bsr_tdo    (bsr_tdo),
    .sys_in     (sys_in),
    .pin_in     (pin_in),
    .pin_out    (pin_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic shift_in(input logic [W-1:0] val);
    bsr_clk   = 1'b1;
    bsr_shift = 1'b1;
    for (int i = 0; i < W; i++) begin
      bsr_tdi = val[i];
      tick();
    end
    bsr_clk = 1'b0;
    bsr_tdi = 1'b0;
  endtask

  logic [W-1:0] exp_bits;
  logic [W-1:0] sweep [5];

  initial begin
    rst        = 1'b1;
    bsr_tdi    = 1'b0;
    bsr_clk    = 1'b0;
    bsr_shift  = 1'b0;
    bsr_update = 1'b0;
    bsr_mode   = 1'b0;
    sys_in     = 8'h3C;
    pin_in     = 8'h00;

    // Reset
    tick();
    tick();
    rst = 1'b0;
    check("reset_tdo", {7'd0, bsr_tdo}, 8'h00);
    check("reset_pin_out", pin_out, 8'h3C);
    check("reset_upd", dut.upd, 8'hA5);
    bsr_mode = 1'b1;
    #1;
    check("mode_not_yet", pin_out, 8'h3C);
    tick();
    check("reset_mode_pin_out", pin_out, 8'hA5);
    bsr_mode = 1'b0;
    tick();

    // Capture and shift-out
    pin_in = 8'hC6;
    tick();
    tick();
    bsr_clk   = 1'b1;
    bsr_shift = 1'b0;
    tick();
    check("capture_chain", dut.chain, 8'hC6);
    bsr_shift = 1'b1;
    bsr_tdi   = 1'b0;
    exp_bits  = 8'hC6;
    for (int i = 0; i < W; i++) begin
      check($sformatf("shift_out_bit%0d", i), {7'd0, bsr_tdo}, {7'd0, exp_bits[i]});
      tick();
    end
    bsr_clk = 1'b0;
    check("chain_empty", dut.chain, 8'h00);

    // Shift-in and update
    bsr_mode = 1'b1;
    tick();
    check("mode_upd_reset", pin_out, 8'hA5);
    shift_in(8'h5A);
    check("shift_in_chain", dut.chain, 8'h5A);
    bsr_update = 1'b1;
    tick();
    check("update_pin_out", pin_out, 8'h5A);
    bsr_clk   = 1'b1;
    bsr_shift = 1'b1;
    bsr_tdi   = 1'b1;
    for (int i = 0; i < W; i++) begin
      tick();
      check($sformatf("held_update_%0d", i), pin_out, 8'h5A);
    end
    bsr_clk    = 1'b0;
    bsr_update = 1'b0;
    bsr_tdi    = 1'b0;
    tick();
    check("held_chain_ff", dut.chain, 8'hFF);
    check("held_upd", dut.upd, 8'h5A);

    // Passthrough
    bsr_mode = 1'b0;
    tick();
    sweep[0] = 8'h00;
    sweep[1] = 8'h01;
    sweep[2] = 8'h55;
    sweep[3] = 8'hAA;
    sweep[4] = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      sys_in = sweep[i];
      #1;
      check($sformatf("passthrough_%0d", i), pin_out, sweep[i]);
    end
    bsr_mode = 1'b1;
    #1;
    check("mode_switch_lag", pin_out, 8'hFF);
    tick();
    check("mode_switch_upd", pin_out, 8'h5A);

    // Simultaneous update and shift
    shift_in(8'h81);
    check("pre_sim_chain", dut.chain, 8'h81);
    bsr_clk    = 1'b1;
    bsr_shift  = 1'b1;
    bsr_tdi    = 1'b1;
    bsr_update = 1'b1;
    tick();
    bsr_clk    = 1'b0;
    bsr_tdi    = 1'b0;
    bsr_update = 1'b0;
    check("sim_upd", dut.upd, 8'h81);
    check("sim_chain", dut.chain, 8'hC0);
    check("sim_pin_out", pin_out, 8'h81);
    tick();

    // Reset mid-scan
    shift_in(8'h5A);
    bsr_update = 1'b1;
    tick();
    bsr_update = 1'b0;
    tick();
    check("rescan_pin_out", pin_out, 8'h5A);
    bsr_clk   = 1'b1;
    bsr_shift = 1'b1;
    bsr_tdi   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
    end
    bsr_clk = 1'b0;
    bsr_tdi = 1'b0;
    sys_in  = 8'h3C;
    rst     = 1'b1;
    tick();
    rst      = 1'b0;
    bsr_mode = 1'b0;
    check("midscan_pin_out", pin_out, 8'h3C);
    check("midscan_chain", dut.chain, 8'h00);
    check("midscan_tdo", {7'd0, bsr_tdo}, 8'h00);
    bsr_update = 1'b1;
    tick();
    bsr_update = 1'b0;
    check("midscan_upd", dut.upd, 8'h00);
    bsr_mode = 1'b1;
    tick();
    check("midscan_mode_pin_out", pin_out, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
